// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and the data memory (slave).
// A request is held until DMEM_ACK; DMEM_RDATA is valid in the ACK cycle.
interface mem_stage_if;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [63:0] DMEM_ADDR;
  logic [63:0] DMEM_WDATA;
  logic [63:0] DMEM_RDATA;
  logic        DMEM_ACK;

  modport master (
    output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA,
    input  DMEM_RDATA, DMEM_ACK
  );

  modport slave (
    input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA,
    output DMEM_RDATA, DMEM_ACK
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage. Non-memory ops pass to MEM/WB in one cycle; loads and
// stores run a request/ack access on the data-memory bus, stalling earlier stages until
// ACK, with a 255-cycle timeout that raises a sticky BUS_ERROR.
// Optional build macro MEM_STAGE_ALIGN_CHECK_EN: rejects memory ops whose address is not
// 8-byte aligned and reports them on the sticky ALIGN_FAULT output.
module mem_stage (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [63:0] ALU_VAL,
  input  logic [63:0] RT_READ,
  input  logic [4:0]  REG_DESTINATION,
  input  logic        REGWRITE_IN,
  input  logic        MEM2REG_IN,
  input  logic        MEMREAD_IN,
  input  logic        MEMWRITE_IN,
  input  logic        BRANCH_ZERO_IN,
  input  logic        ZERO,
  input  logic [63:0] BRANCH,
  input  logic [31:0] INSTR_IN,
  mem_stage_if.master dmem,
  output logic        STALL,
  output logic        PCSRC,
  output logic [63:0] BRANCH_TARGET_OUT,
  output logic [63:0] READ_DATA_OUT,
  output logic [63:0] ALU_VAL_OUT,
  output logic [4:0]  REG_DESTINATION_OUT,
  output logic        REGWRITE_OUT,
  output logic        MEM2REG_OUT,
  output logic [31:0] INSTR_OUT,
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  output logic        ALIGN_FAULT,
`endif
  output logic        BUS_ERROR
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        bus_error_q;
  logic        bus_err_set;
  logic        stall;
  logic        req;
  logic        wb_take;   // 1: MEM/WB loads the instruction, 0: MEM/WB loads a bubble
  logic [63:0] wb_rdata;
  logic        mem_op;
  logic        is_load;

  logic [63:0] read_data_q;
  logic [63:0] alu_val_q;
  logic [4:0]  reg_dest_q;
  logic        regwrite_q;
  logic        mem2reg_q;
  logic [31:0] instr_q;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic        align_set;
  logic        align_fault_q;
`endif

  assign mem_op  = MEMREAD_IN | MEMWRITE_IN;
  // A write wins when both read and write are set.
  assign is_load = MEMREAD_IN & ~MEMWRITE_IN;

  // Next-state, bus request and MEM/WB load selection.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall       = 1'b0;
    req         = 1'b0;
    wb_take     = 1'b0;
    wb_rdata    = '0;
    bus_err_set = 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    align_set   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (!mem_op) begin
          wb_take = 1'b1;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        end else if (ALU_VAL[2:0] != 3'b000) begin
          align_set = 1'b1;
`endif
        end else begin
          stall      = 1'b1;
          state_d    = StBusy;
          wait_cnt_d = '0;
        end
      end
      StBusy: begin
        req = 1'b1;
        if (dmem.DMEM_ACK) begin
          wb_take  = 1'b1;
          wb_rdata = is_load ? dmem.DMEM_RDATA : '0;
          state_d  = StIdle;
        end else if (wait_cnt_q == 8'hFF) begin
          // Timeout: abandon the access and let the pipeline move on.
          req         = 1'b0;
          bus_err_set = 1'b1;
          state_d     = StIdle;
        end else begin
          stall      = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Bus and stall are quiet while reset is held.
    if (!RESET) begin
      stall = 1'b0;
      req   = 1'b0;
    end
  end

  // FSM state, wait counter and sticky error flags.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      bus_error_q   <= 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      align_fault_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      bus_error_q   <= bus_error_q | bus_err_set;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      align_fault_q <= align_fault_q | align_set;
`endif
    end
  end

  // MEM/WB register: instruction on completion, fully zeroed bubble otherwise.
  always_ff @(posedge CLK) begin
    if (!RESET || !wb_take) begin
      read_data_q <= '0;
      alu_val_q   <= '0;
      reg_dest_q  <= '0;
      regwrite_q  <= 1'b0;
      mem2reg_q   <= 1'b0;
      instr_q     <= '0;
    end else begin
      read_data_q <= wb_rdata;
      alu_val_q   <= ALU_VAL;
      reg_dest_q  <= REG_DESTINATION;
      regwrite_q  <= REGWRITE_IN;
      mem2reg_q   <= MEM2REG_IN;
      instr_q     <= INSTR_IN;
    end
  end

  // Address and store data come straight from EX/MEM, which STALL holds steady.
  assign dmem.DMEM_REQ   = req;
  assign dmem.DMEM_WE    = req & MEMWRITE_IN;
  assign dmem.DMEM_ADDR  = req ? ALU_VAL : '0;
  assign dmem.DMEM_WDATA = req ? RT_READ : '0;

  assign STALL               = stall;
  assign PCSRC               = BRANCH_ZERO_IN & ZERO & ~stall;
  assign BRANCH_TARGET_OUT   = BRANCH;
  assign READ_DATA_OUT       = read_data_q;
  assign ALU_VAL_OUT         = alu_val_q;
  assign REG_DESTINATION_OUT = reg_dest_q;
  assign REGWRITE_OUT        = regwrite_q;
  assign MEM2REG_OUT         = mem2reg_q;
  assign INSTR_OUT           = instr_q;
  assign BUS_ERROR           = bus_error_q;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign ALIGN_FAULT         = align_fault_q;
`endif

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports (clock and reset first):
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-low reset
- ALU_VAL  in  64  address / ALU result from EX/MEM
- RT_READ  in  64  store data
- REG_DESTINATION  in  5  writeback register
- REGWRITE_IN, MEM2REG_IN, MEMREAD_IN, MEMWRITE_IN, BRANCH_ZERO_IN, ZERO  in  1 each  EX/MEM control
- BRANCH  in  64  branch target
- INSTR_IN  in  32  instruction tag
- DMEM_RDATA  in  64  memory read data
- DMEM_ACK  in  1  memory completion
- DMEM_REQ  out  1  memory request
- DMEM_WE  out  1  store strobe
- DMEM_ADDR  out  64  memory address
- DMEM_WDATA  out  64  store data
- STALL  out  1  hold EX/MEM and earlier stages
- PCSRC  out  1  take branch
- BRANCH_TARGET_OUT  out  64  PC for taken branch
- READ_DATA_OUT, ALU_VAL_OUT  out  64 each  MEM/WB data
- REG_DESTINATION_OUT  out  5
- REGWRITE_OUT, MEM2REG_OUT  out  1 each
- INSTR_OUT  out  32
- BUS_ERROR  out  1  sticky timeout flag
REQ-002 SHALL use one clock domain: CLK. Reset is synchronous and active-low (RESET).

Function
REQ-003 SHALL implement FSM states IDLE and BUSY.
REQ-004 In IDLE, a non-memory op (MEMREAD_IN=0, MEMWRITE_IN=0) SHALL load MEM/WB outputs from inputs at the next edge, with READ_DATA_OUT=0. Latency is 1 cycle and STALL=0.
REQ-005 In IDLE, a memory op SHALL drive STALL=1 combinationally and transition to BUSY. MEM/WB SHALL load a bubble: REGWRITE_OUT=0, MEM2REG_OUT=0, INSTR_OUT=0.
REQ-006 In BUSY:
- DMEM_REQ=1, DMEM_ADDR=ALU_VAL, DMEM_WDATA=RT_READ, DMEM_WE=MEMWRITE_IN.
- All four are held stable until ACK.
REQ-007 In BUSY with DMEM_ACK=0, the block SHALL keep STALL=1 and load a bubble into MEM/WB.
REQ-008 In BUSY with DMEM_ACK=1:
- STALL=0.
- At the edge, MEM/WB SHALL load the instruction, with READ_DATA_OUT=DMEM_RDATA for loads and 0 for stores.
- FSM SHALL return to IDLE.
REQ-009 Minimum memory-op latency SHALL be 2 cycles (ACK in the first BUSY cycle). Each cycle of ACK delay SHALL add one cycle.
REQ-010 DMEM_ACK outside BUSY SHALL be ignored.
REQ-011 An instruction with both MEMREAD_IN and MEMWRITE_IN set SHALL be treated as a store.
REQ-012 PCSRC SHALL equal BRANCH_ZERO_IN & ZERO & ~STALL (combinational). BRANCH_TARGET_OUT SHALL equal BRANCH.
REQ-013 Timeout:
- An 8-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ACK.
- When the counter reaches 255 without ACK, the block SHALL drop DMEM_REQ, set BUS_ERROR, force STALL=0, load a bubble into MEM/WB and return to IDLE.
REQ-014 ACK arriving in the same cycle the counter reaches 255 SHALL win: normal completion, no BUS_ERROR.
REQ-015 BUS_ERROR SHALL remain set until reset.

Reset
REQ-016 RESET=0 at an edge SHALL force IDLE, counter=0 and BUS_ERROR=0, and zero all registered outputs.
REQ-017 While RESET=0, DMEM_REQ, DMEM_WE and STALL SHALL be 0.
REQ-018 Reset during BUSY SHALL abandon the access with no MEM/WB update. A late ACK after reset SHALL be ignored.

Configuration
REQ-019 Macro MEM_STAGE_ALIGN_CHECK_EN, when defined:
- A memory op in IDLE with ALU_VAL[2:0]!=0 SHALL NOT enter BUSY or assert DMEM_REQ.
- It SHALL load a bubble, assert the extra output ALIGN_FAULT (1 bit, sticky until reset) and keep STALL=0.
REQ-020 Without the macro, no alignment check is made, the ALIGN_FAULT port is absent, and misaligned addresses are issued unchanged.

Verification
REQ-021 ALU op, ALU_VAL=0x10, REGWRITE_IN=1, RD=3 -> next cycle ALU_VAL_OUT=0x10, REG_DESTINATION_OUT=3, REGWRITE_OUT=1, STALL never 1.
REQ-022 Load at 0x40, ACK after 3 BUSY cycles with RDATA=0xDEADBEEF -> STALL high for 4 cycles, then READ_DATA_OUT=0xDEADBEEF, MEM2REG_OUT=1, REGWRITE_OUT=1.
REQ-023 Store 0x55 to 0x80, ACK immediate -> DMEM_WE=1, DMEM_WDATA=0x55 for 1 cycle, 2-cycle latency, REGWRITE_OUT=0.
REQ-024 Load, never ACK -> after 255 BUSY cycles DMEM_REQ=0, BUS_ERROR=1, STALL=0, bubble output.
REQ-025 RESET=0 during 2nd BUSY cycle, then ACK -> all outputs 0, FSM IDLE, ACK ignored.
REQ-026 With MEM_STAGE_ALIGN_CHECK_EN, load at 0x43 -> DMEM_REQ stays 0, ALIGN_FAULT=1, REGWRITE_OUT=0.
